// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding NREQ frame requesters into one UART transmitter
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   REQ, REQ_DATA       per-requester request and DATA_WIDTH-bit frame data lanes
//   REQ_PAR_EN          per-requester parity enable
//   GNT                 one-hot acknowledge, high in the launch cycle only
//   TX_BUSY             busy flag from the transmitter
//   TX_DATA_VALID       one-cycle launch strobe, TX_P_DATA/TX_PAR_EN latched frame fields
//   ARB_BUSY            high whenever the arbiter is not idle
//   TIMEOUT_ERR         one-cycle watchdog pulse, only with UART_TX_ARB_TIMEOUT_EN defined
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NREQ-1:0]            REQ,
  input  logic [NREQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NREQ-1:0]            REQ_PAR_EN,
  output logic [NREQ-1:0]            GNT,
  input  logic                       TX_BUSY,
  output logic                       TX_DATA_VALID,
  output logic [DATA_WIDTH-1:0]      TX_P_DATA,
  output logic                       TX_PAR_EN,
  output logic                       ARB_BUSY,
  output logic                       TIMEOUT_ERR
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;
  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d, win_q, win_d, pick, idx;
  logic [PW:0]           sum;
  logic                  found;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_q, par_d;
  // first requesting index at or after the pointer, wrapping modulo NREQ
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      idx = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];
      if (!found && REQ[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          expired;
  assign expired = !TX_BUSY && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign to_d    = state_q == WAIT_START && expired;
  assign cnt_d   = (state_q == WAIT_START && state_d == WAIT_START) ? cnt_q + CW'(1) : '0;
  assign TIMEOUT_ERR = to_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`else
  logic expired;
  logic unused_tc;
  assign expired     = 1'b0;
  assign unused_tc   = ^TIMEOUT_CYCLES;
  assign TIMEOUT_ERR = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    data_d  = data_q;
    par_d   = par_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = LAUNCH;
        win_d   = pick;
        ptr_d   = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
        data_d  = REQ_DATA[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
        par_d   = REQ_PAR_EN[pick];
      end
      LAUNCH:     state_d = WAIT_START;
      WAIT_START: state_d = TX_BUSY ? WAIT_DONE : (expired ? IDLE : WAIT_START);
      WAIT_DONE:  state_d = TX_BUSY ? WAIT_DONE : IDLE;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end
  end
  assign TX_DATA_VALID = state_q == LAUNCH;
  assign GNT           = TX_DATA_VALID ? (NREQ)'(1) << win_q : '0;
  assign TX_P_DATA     = data_q;
  assign TX_PAR_EN     = par_q;
  assign ARB_BUSY      = state_q != IDLE;
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: frame data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: watchdog limit in cycles, used only when UART_TX_ARB_TIMEOUT_EN is defined.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports named CLK and RST.
REQ-005 CLK  input  1  clock; all state changes on the rising edge.
REQ-006 RST  input  1  reset: synchronous, active-high.
REQ-007 REQ  input  NREQ  per-requester frame request; requester holds it high until its GNT bit pulses.
REQ-008 REQ_DATA  input  NREQ*DATA_WIDTH  per-requester frame data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 REQ_PAR_EN  input  NREQ  per-requester parity enable.
REQ-010 GNT  output  NREQ  one-hot, one-cycle acknowledge that the requester's data was captured.
REQ-011 TX_BUSY  input  1  BUSY flag from the UART transmitter.
REQ-012 TX_DATA_VALID  output  1  one-cycle launch strobe to the transmitter.
REQ-013 TX_P_DATA  output  DATA_WIDTH  latched frame data to the transmitter.
REQ-014 TX_PAR_EN  output  1  latched parity enable to the transmitter.
REQ-015 ARB_BUSY  output  1  high in every state except IDLE.
REQ-016 TIMEOUT_ERR  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-017 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
REQ-018 IDLE: if any REQ bit is high, select the winner by round-robin and go to LAUNCH at the next edge; otherwise stay in IDLE.
REQ-019 Round-robin: search starts at pointer PTR and increases modulo NREQ; after a grant, PTR becomes (winner+1) mod NREQ.
REQ-020 On the IDLE->LAUNCH edge, the block SHALL register the winner's REQ_DATA into TX_P_DATA and REQ_PAR_EN into TX_PAR_EN.
REQ-021 LAUNCH lasts exactly 1 cycle: TX_DATA_VALID=1, GNT[winner]=1, then go to WAIT_START.
REQ-022 Latency: REQ sampled high in IDLE at cycle n -> GNT and TX_DATA_VALID high in cycle n+1.
REQ-023 WAIT_START: stay until TX_BUSY=1, then go to WAIT_DONE.
REQ-024 WAIT_DONE: stay until TX_BUSY=0, then go to IDLE.
REQ-025 REQ is ignored outside IDLE; a REQ still high during the GNT cycle SHALL NOT cause a second grant to the same frame.
REQ-026 TX_P_DATA and TX_PAR_EN SHALL hold stable from LAUNCH until the next grant.
REQ-027 Back-to-back operation: a pending REQ is granted with TX_DATA_VALID in the second cycle after TX_BUSY is observed low (IDLE takes one cycle).
REQ-028 Simultaneous requests: exactly one grant per frame; no requester waits more than NREQ-1 frames.
REQ-029 GNT is zero whenever TX_DATA_VALID is zero.

Reset
REQ-030 While RST=1 at a clock edge, the block SHALL set state=IDLE, PTR=0, GNT=0, TX_DATA_VALID=0, TX_P_DATA=0, TX_PAR_EN=0, ARB_BUSY=0, TIMEOUT_ERR=0, and clear the watchdog counter.
REQ-031 Reset mid-operation: any in-flight frame is abandoned; the block does not abort the transmitter; the first grant after reset follows normal IDLE rules.

Configuration
REQ-032 Macro UART_TX_ARB_TIMEOUT_EN defined: a counter runs in WAIT_START. If TX_BUSY is still 0 after TIMEOUT_CYCLES cycles in WAIT_START, the block returns to IDLE and pulses TIMEOUT_ERR for 1 cycle; the already-granted frame is not re-issued.
REQ-033 Macro UART_TX_ARB_TIMEOUT_EN not defined: there is no counter; WAIT_START waits indefinitely and TIMEOUT_ERR is tied to 0.

Verification
REQ-034 Single request: REQ=4'b0100, REQ_DATA[23:16]=8'hA5, REQ_PAR_EN[2]=1 -> next cycle GNT=4'b0100, TX_DATA_VALID=1, TX_P_DATA=8'hA5, TX_PAR_EN=1; ARB_BUSY stays high until TX_BUSY falls.
REQ-035 All four requesting continuously, TX model BUSY for 11 cycles per frame -> grant order 0,1,2,3,0; exactly one GNT pulse per frame.
REQ-036 Back-to-back: REQ[1] held high while TX_BUSY falls -> TX_DATA_VALID reasserts exactly 2 cycles after TX_BUSY is first sampled 0.
REQ-037 Reset in WAIT_DONE with REQ=4'b1000 pending -> all outputs 0 after the edge; PTR=0; the next grant goes to requester 3 one cycle after RST drops.
REQ-038 With UART_TX_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, TX_BUSY tied 0 -> TIMEOUT_ERR pulses 16 cycles after WAIT_START entry, then the block returns to IDLE; without the macro, the block stays in WAIT_START and TIMEOUT_ERR stays 0.
